// File: rtl/iiitb_sdm.sv
// Serial 1-0-1-0 pattern detector (Moore FSM), overlapping or non-overlapping per OVERLAP.
// Latency: y asserts on the same rising edge that samples the final '0' of a match; registered-state decode only.
// Backpressure: none; one bit is consumed every clock, and y is a one-cycle strobe per detected match.
module iiitb_sdm #(
    parameter int OVERLAP = 1
) (
    input  logic din,
    input  logic reset,
    input  logic clk,
    output logic y
);

    typedef enum logic [2:0] {
        S0 = 3'd0,   // idle, no progress
        S1 = 3'd1,   // seen "1"
        S2 = 3'd2,   // seen "10"
        S3 = 3'd3,   // seen "101"
        S4 = 3'd4    // seen "1010", detect
    } state_t;

    state_t state_q;
    state_t state_d;

    // State register; reset wins over any transition and discards partial progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and Moore output decode; unused encodings fall back to S0.
    always_comb begin
        state_d = S0;
        y       = 1'b0;
        case (state_q)
            S0: state_d = din ? S1 : S0;
            S1: state_d = din ? S1 : S2;
            S2: state_d = din ? S3 : S0;
            S3: state_d = din ? S1 : S4;
            S4: begin
                y = 1'b1;
                // With overlap, the trailing "10" of a match is reused, so a 1 lands in "101".
                if (din) begin
                    state_d = (OVERLAP != 0) ? S3 : S1;
                end else begin
                    state_d = S0;
                end
            end
            default: state_d = S0;
        endcase
    end

endmodule

// File: tb/tb_iiitb_sdm.sv
// Bench for the 1010 detector: both OVERLAP variants driven from one stream.
// Checks each cycle against a sliding-window model of the sampled bit history.
// Directed test-plan sequences first, then a randomized run with sparse resets.
module tb_iiitb_sdm;

    logic clk = 1'b0;
    logic din = 1'b0;
    logic reset = 1'b1;
    logic y_ov;
    logic y_no;

    int checks = 0;
    int failures = 0;

    // Reference model state: recent bits plus how many bits count toward a match.
    logic [3:0] win = 4'b0000;
    int cnt_ov = 0;
    int cnt_no = 0;
    logic exp_ov = 1'b0;
    logic exp_no = 1'b0;

    // Pulse tallies for per-sequence summary checks.
    int pulses_ov = 0;
    int pulses_no = 0;

    iiitb_sdm #(.OVERLAP(1)) u_dut_ov (
        .din   (din),
        .reset (reset),
        .clk   (clk),
        .y     (y_ov)
    );

    iiitb_sdm #(.OVERLAP(0)) u_dut_no (
        .din   (din),
        .reset (reset),
        .clk   (clk),
        .y     (y_no)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: drive on the falling edge, update the model, check just after the rising edge.
    task automatic step(input logic d, input logic r, input string tag);
        @(negedge clk);
        din   = d;
        reset = r;
        @(posedge clk);
        if (r) begin
            cnt_ov = 0;
            cnt_no = 0;
            win    = 4'b0000;
            exp_ov = 1'b0;
            exp_no = 1'b0;
        end else begin
            win    = {win[2:0], d};
            cnt_ov = cnt_ov + 1;
            cnt_no = cnt_no + 1;
            exp_ov = (cnt_ov >= 4) && (win == 4'b1010);
            exp_no = (cnt_no >= 4) && (win == 4'b1010);
            // A non-overlapping match consumes its bits entirely.
            if (exp_no) cnt_no = 0;
        end
        #1;
        chk({tag, "_ov"}, {31'd0, y_ov}, {31'd0, exp_ov});
        chk({tag, "_no"}, {31'd0, y_no}, {31'd0, exp_no});
        if (y_ov === 1'b1) pulses_ov++;
        if (y_no === 1'b1) pulses_no++;
    endtask

    // Feed n bits, earliest bit in the most significant position of the n-bit field.
    task automatic feed(input logic [15:0] bits, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(bits[n-1-i], 1'b0, tag);
        end
    endtask

    task automatic clear_tallies();
        pulses_ov = 0;
        pulses_no = 0;
    endtask

    initial begin
        // Reset held with din toggling: y must stay low.
        step(1'b1, 1'b1, "rst");
        chk("rst_y_ov", {31'd0, y_ov}, 32'd0);
        chk("rst_y_no", {31'd0, y_no}, 32'd0);
        for (int i = 0; i < 6; i++) step(i[0], 1'b1, "rst_hold");

        // Single match then a trailing 0.
        clear_tallies();
        feed(16'b01010, 5, "single");
        chk("single_pulse", {31'd0, y_ov}, 32'd1);
        step(1'b0, 1'b0, "single_after");
        chk("single_after_y", {31'd0, y_ov}, 32'd0);
        chk("single_cnt_ov", pulses_ov, 32'd1);

        // Overlap stream: two pulses with overlap, one without.
        step(1'b0, 1'b1, "rst");
        clear_tallies();
        feed(16'b1010100100, 10, "ovl");
        chk("ovl_cnt_ov", pulses_ov, 32'd2);
        chk("ovl_cnt_no", pulses_no, 32'd1);

        // Near misses: no detect anywhere.
        step(1'b0, 1'b1, "rst");
        clear_tallies();
        feed(16'b11011001011, 11, "near");
        chk("near_cnt_ov", pulses_ov, 32'd0);
        chk("near_cnt_no", pulses_no, 32'd0);

        // Repeated 1s stay in the "1" state and still lead into a match.
        step(1'b0, 1'b1, "rst");
        clear_tallies();
        feed(16'b11010, 5, "s1loop");
        chk("s1loop_y", {31'd0, y_ov}, 32'd1);

        // Reset mid-sequence discards progress; a fresh 1010 gives one pulse.
        step(1'b0, 1'b1, "rst");
        clear_tallies();
        feed(16'b101, 3, "mid");
        step(1'b0, 1'b1, "mid_rst");
        feed(16'b0, 1, "mid_post");
        chk("mid_cnt_nodetect", pulses_ov, 32'd0);
        feed(16'b1010, 4, "mid_again");
        chk("mid_cnt_ov", pulses_ov, 32'd1);
        chk("mid_cnt_no", pulses_no, 32'd1);

        // Randomized stream with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
